// File: rtl/sram_pkg.sv
// Constants, FSM encoding and sample-format helper shared by the SRAM capture and playback paths.
package sram_pkg;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 15360;

   typedef logic [2:0] state_t;

   localparam state_t StIdle      = 3'd0;
   localparam state_t StCapWait   = 3'd1;
   localparam state_t StCapSetup  = 3'd2;
   localparam state_t StCapStrobe = 3'd3;
   localparam state_t StRdAddr    = 3'd4;
   localparam state_t StRdLatch   = 3'd5;
   localparam state_t StRdHold    = 3'd6;

   // Offset binary <-> two's complement is the same MSB flip in both directions.
   function automatic logic [DATA_W-1:0] flip_msb(input logic [DATA_W-1:0] s);
      return {~s[DATA_W-1], s[DATA_W-2:0]};
   endfunction

endpackage

// File: rtl/sram_bus_if.sv
// SRAM pin driver: registered address and strobes, plus ownership of the data_io tri-state.
module sram_bus_if import sram_pkg::*; #(
   parameter int unsigned AW = ADDR_W,
   parameter int unsigned DW = DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          addr_ld,
   input  logic [AW-1:0] addr_nxt,
   input  logic          we_n_nxt,
   input  logic          oe_n_nxt,
   input  logic          drive_nxt,
   input  logic          wdata_ld,
   input  logic [DW-1:0] wdata_nxt,
   output logic [DW-1:0] rdata,
   inout  wire  [DW-1:0] data_io,
   output logic [AW-1:0] addr,
   output logic          ce_n,
   output logic          oe_n,
   output logic          we_n
);

   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          we_n_q;
   logic          oe_n_q;
   logic          drive_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         drive_q <= 1'b0;
      end else begin
         if (addr_ld)  addr_q  <= addr_nxt;
         if (wdata_ld) wdata_q <= wdata_nxt;
         we_n_q  <= we_n_nxt;
         // Either direction only turns on after a full cycle with the other one off.
         oe_n_q  <= oe_n_nxt | drive_nxt | drive_q;
         drive_q <= drive_nxt & oe_n_q & oe_n_nxt;
      end
   end

   assign data_io = drive_q ? wdata_q : {DW{1'bz}};
   assign rdata   = data_io;
   assign addr    = addr_q;
   assign we_n    = we_n_q;
   assign oe_n    = oe_n_q;
   assign ce_n    = 1'b0;

endmodule

// File: rtl/adc_sram_capture.sv
// ADC capture into async SRAM with block read-back to the MCU over valid/ready.
module adc_sram_capture #(
   parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
   parameter int unsigned DATA_W = sram_pkg::DATA_W,
   parameter int unsigned DEPTH  = sram_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_capture,
   input  logic              stop_capture,
   input  logic              start_readout,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   inout  wire  [DATA_W-1:0] data_io,
   output logic [ADDR_W-1:0] addr,
   output logic              ce_n,
   output logic              oe_n,
   output logic              we_n,
   output logic [DATA_W-1:0] mcu_data,
   output logic              mcu_valid,
   input  logic              mcu_ready,
   output logic [ADDR_W-1:0] sample_count,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] DepthCnt = ADDR_W'(DEPTH);

   sram_pkg::state_t  state_q, state_d;
   logic [ADDR_W-1:0] w_count_q, w_count_d, r_count_q, r_count_d;
   logic [ADDR_W-1:0] sample_count_q, sample_count_d;
   logic [ADDR_W-1:0] w_count_inc, r_count_inc, addr_nxt;
   logic [DATA_W-1:0] hold_data_q, hold_data_d, mcu_data_q, mcu_data_d, rdata;
   logic              hold_full_q, hold_full_d, overrun_q, overrun_d;
   logic              stop_pend_q, stop_pend_d, mcu_valid_q, mcu_valid_d, done_q, done_d;
   logic              addr_ld, we_n_nxt, oe_n_nxt, drive_nxt, wdata_ld, hold_pop, capturing;

   assign w_count_inc = w_count_q + 1'b1;
   assign r_count_inc = r_count_q + 1'b1;

   always_comb begin
      state_d        = state_q;
      w_count_d      = w_count_q;
      r_count_d      = r_count_q;
      sample_count_d = sample_count_q;
      hold_data_d    = hold_data_q;
      hold_full_d    = hold_full_q;
      overrun_d      = overrun_q;
      stop_pend_d    = stop_pend_q;
      mcu_data_d     = mcu_data_q;
      mcu_valid_d    = mcu_valid_q;
      done_d         = 1'b0;
      addr_ld        = 1'b0;
      addr_nxt       = w_count_q;
      we_n_nxt       = 1'b1;
      oe_n_nxt       = 1'b1;
      drive_nxt      = 1'b0;
      wdata_ld       = 1'b0;
      hold_pop       = 1'b0;
      capturing      = (state_q == sram_pkg::StCapWait) || (state_q == sram_pkg::StCapSetup) ||
                       (state_q == sram_pkg::StCapStrobe);

      unique case (state_q)
         sram_pkg::StIdle: begin
            if (start_capture) begin
               state_d     = sram_pkg::StCapWait;
               w_count_d   = '0;
               overrun_d   = 1'b0;
               stop_pend_d = 1'b0;
            end else if (start_readout) begin
               if (sample_count_q == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = sram_pkg::StRdAddr;
                  r_count_d = '0;
               end
            end
         end
         sram_pkg::StCapWait: begin
            if (stop_capture || stop_pend_q) begin
               state_d        = sram_pkg::StIdle;
               sample_count_d = w_count_q;
               done_d         = 1'b1;
               stop_pend_d    = 1'b0;
            end else if (hold_full_q) begin
               state_d   = sram_pkg::StCapSetup;
               addr_ld   = 1'b1;
               addr_nxt  = w_count_q;
               drive_nxt = 1'b1;
               wdata_ld  = 1'b1;
            end
         end
         sram_pkg::StCapSetup: begin
            state_d   = sram_pkg::StCapStrobe;
            drive_nxt = 1'b1;
            we_n_nxt  = 1'b0;
            if (stop_capture) stop_pend_d = 1'b1;
         end
         sram_pkg::StCapStrobe: begin
            // Keep driving through the cycle after we_n rises for data hold time.
            drive_nxt = 1'b1;
            hold_pop  = 1'b1;
            w_count_d = w_count_inc;
            if (stop_capture) stop_pend_d = 1'b1;
            if (w_count_inc == DepthCnt) begin
               state_d        = sram_pkg::StIdle;
               sample_count_d = w_count_inc;
               done_d         = 1'b1;
               stop_pend_d    = 1'b0;
            end else begin
               state_d = sram_pkg::StCapWait;
            end
         end
         sram_pkg::StRdAddr: begin
            state_d  = sram_pkg::StRdLatch;
            addr_ld  = 1'b1;
            addr_nxt = r_count_q;
            oe_n_nxt = 1'b0;
         end
         sram_pkg::StRdLatch: begin
            state_d     = sram_pkg::StRdHold;
            mcu_data_d  = rdata;
            mcu_valid_d = 1'b1;
         end
         sram_pkg::StRdHold: begin
            if (mcu_valid_q && mcu_ready) begin
               mcu_valid_d = 1'b0;
               r_count_d   = r_count_inc;
               if (r_count_inc == sample_count_q) begin
                  state_d = sram_pkg::StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = sram_pkg::StRdAddr;
               end
            end
         end
         default: state_d = sram_pkg::StIdle;
      endcase

      // A sample arriving in the cycle the register drains is accepted.
      if (hold_pop) hold_full_d = 1'b0;
      if (capturing && adc_valid) begin
         if (!hold_full_q || hold_pop) begin
            hold_full_d = 1'b1;
            hold_data_d = sram_pkg::flip_msb(adc_data);
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (state_d == sram_pkg::StIdle) hold_full_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= sram_pkg::StIdle;
         w_count_q      <= '0;
         r_count_q      <= '0;
         sample_count_q <= '0;
         hold_data_q    <= '0;
         hold_full_q    <= 1'b0;
         overrun_q      <= 1'b0;
         stop_pend_q    <= 1'b0;
         mcu_data_q     <= '0;
         mcu_valid_q    <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         w_count_q      <= w_count_d;
         r_count_q      <= r_count_d;
         sample_count_q <= sample_count_d;
         hold_data_q    <= hold_data_d;
         hold_full_q    <= hold_full_d;
         overrun_q      <= overrun_d;
         stop_pend_q    <= stop_pend_d;
         mcu_data_q     <= mcu_data_d;
         mcu_valid_q    <= mcu_valid_d;
         done_q         <= done_d;
      end
   end

   sram_bus_if #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_bus (
      .clk       (clk),
      .rst       (rst),
      .addr_ld   (addr_ld),
      .addr_nxt  (addr_nxt),
      .we_n_nxt  (we_n_nxt),
      .oe_n_nxt  (oe_n_nxt),
      .drive_nxt (drive_nxt),
      .wdata_ld  (wdata_ld),
      .wdata_nxt (hold_data_q),
      .rdata     (rdata),
      .data_io   (data_io),
      .addr      (addr),
      .ce_n      (ce_n),
      .oe_n      (oe_n),
      .we_n      (we_n)
   );

   assign mcu_data     = mcu_data_q;
   assign mcu_valid    = mcu_valid_q;
   assign sample_count = sample_count_q;
   assign busy         = (state_q != sram_pkg::StIdle);
   assign done         = done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sram_capture.sv
// Directed bench for adc_sram_capture with a behavioural async SRAM on data_io.
module tb_adc_sram_capture;

   logic        clk;
   logic        rst;
   logic        start_capture, stop_capture, start_readout;
   logic [7:0]  adc_data;
   logic        adc_valid;
   wire  [7:0]  data_io;
   logic [18:0] addr;
   logic        ce_n, oe_n, we_n;
   logic [7:0]  mcu_data;
   logic        mcu_valid, mcu_ready;
   logic [18:0] sample_count;
   logic        busy, done, overrun;

   adc_sram_capture #(
      .ADDR_W (19),
      .DATA_W (8),
      .DEPTH  (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_capture (start_capture),
      .stop_capture  (stop_capture),
      .start_readout (start_readout),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .data_io       (data_io),
      .addr          (addr),
      .ce_n          (ce_n),
      .oe_n          (oe_n),
      .we_n          (we_n),
      .mcu_data      (mcu_data),
      .mcu_valid     (mcu_valid),
      .mcu_ready     (mcu_ready),
      .sample_count  (sample_count),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: reads are combinational, writes land while we_n is low.
   logic [7:0] mem [0:15];
   logic       sram_oe;
   assign sram_oe = !ce_n && !oe_n && we_n;
   assign data_io = sram_oe ? mem[addr[3:0]] : 8'hzz;

   int done_cnt = 0, valid_cnt = 0, conflict_cnt = 0, wr_cnt = 0;
   always @(negedge clk) begin
      if (!ce_n && !we_n) begin
         mem[addr[3:0]] = data_io;
         wr_cnt++;
      end
      if (done) done_cnt++;
      if (mcu_valid) valid_cnt++;
      if (!oe_n && dut.u_bus.drive_q) conflict_cnt++;
   end

   typedef struct {
      logic [7:0] adc;
      logic [7:0] exp;
   } vec_t;
   vec_t vec [8];

   int n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm, input int max);
      int t = 0;
      while (busy && t < max) begin
         tick();
         t++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   task automatic capture(input int base, input int n, input int gap);
      int d0 = done_cnt;
      start_capture = 1'b1; tick(); start_capture = 1'b0;
      for (int i = 0; i < n; i++) begin
         adc_valid = 1'b1;
         adc_data  = vec[base+i].adc;
         tick();
         adc_valid = 1'b0;
         repeat (gap - 1) tick();
      end
      wait_idle("cap_idle", 40);
      repeat (2) tick();
      chk("cap_count", 32'(sample_count), 32'(n));
      chk("cap_done", 32'(done_cnt - d0), 32'd1);
      chk("cap_overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < n; i++) chk("cap_mem", 32'(mem[i]), 32'(vec[base+i].exp));
   endtask

   task automatic readout(input int base, input int n, input int stall_idx);
      logic [7:0]  got_d [$];
      logic [18:0] got_a [$];
      int k = 0, t = 0, stall = 0, d0 = done_cnt;
      start_readout = 1'b1; tick(); start_readout = 1'b0;
      while (busy && t < 200) begin
         mcu_ready = (stall_idx < 0);
         if (mcu_valid) begin
            if (k == stall_idx && stall < 10) begin
               chk("bp_hold", {16'd0, mcu_data, addr[7:0]}, {16'd0, vec[base+k].exp, 8'(k)});
               stall++;
            end else begin
               got_d.push_back(mcu_data);
               got_a.push_back(addr);
               mcu_ready = 1'b1;
               k++;
            end
         end
         tick();
         t++;
      end
      mcu_ready = 1'b0;
      repeat (2) tick();
      chk("rd_busy", 32'(busy), 32'd0);
      chk("rd_len", 32'(got_d.size()), 32'(n));
      for (int i = 0; i < got_d.size() && i < n; i++) begin
         chk("rd_data", 32'(got_d[i]), 32'(vec[base+i].exp));
         chk("rd_addr", 32'(got_a[i]), 32'(i));
      end
      chk("rd_done", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int d0, v0, w0;
      vec[0] = '{8'h00, 8'h80};
      vec[1] = '{8'h80, 8'h00};
      vec[2] = '{8'hFF, 8'h7F};
      vec[3] = '{8'h7F, 8'hFF};
      vec[4] = '{8'h01, 8'h81};
      vec[5] = '{8'hC3, 8'h43};
      vec[6] = '{8'h55, 8'hD5};
      vec[7] = '{8'hAA, 8'h2A};

      rst = 1'b1;
      start_capture = 1'b0; stop_capture = 1'b0; start_readout = 1'b0;
      adc_data = 8'h00; adc_valid = 1'b0; mcu_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_flags", {27'd0, busy, done, overrun, mcu_valid, dut.u_bus.drive_q}, 32'd0);
      chk("rst_count", 32'(sample_count), 32'd0);
      chk("rst_mcu_data", 32'(mcu_data), 32'd0);

      // Readout of an empty capture only pulses done.
      d0 = done_cnt; v0 = valid_cnt;
      start_readout = 1'b1; tick(); start_readout = 1'b0;
      repeat (3) tick();
      chk("empty_rd_done", 32'(done_cnt - d0), 32'd1);
      chk("empty_rd_valid", 32'(valid_cnt - v0), 32'd0);
      chk("empty_rd_busy", 32'(busy), 32'd0);

      // Table blocks: spacing 4, then the minimum spacing of 3.
      capture(0, 4, 4);
      readout(0, 4, -1);
      readout(0, 4, 1);
      capture(4, 4, 3);
      readout(4, 4, -1);

      // Overrun: three back-to-back samples, only the first fits.
      d0 = done_cnt;
      start_capture = 1'b1; tick(); start_capture = 1'b0;
      for (int i = 0; i < 3; i++) begin
         adc_valid = 1'b1; adc_data = vec[i].adc; tick();
      end
      adc_valid = 1'b0;
      repeat (4) tick();
      stop_capture = 1'b1; tick(); stop_capture = 1'b0;
      wait_idle("ovr_idle", 20);
      repeat (3) tick();
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_count", 32'(sample_count), 32'd1);
      chk("ovr_mem", 32'(mem[0]), 32'(vec[0].exp));
      start_capture = 1'b1; tick(); start_capture = 1'b0;
      chk("ovr_clear", 32'(overrun), 32'd0);
      stop_capture = 1'b1; tick(); stop_capture = 1'b0;
      wait_idle("ovr_stop_idle", 20);

      // Stop lands during the second write's setup and is honoured after it.
      start_capture = 1'b1; tick(); start_capture = 1'b0;
      adc_valid = 1'b1; adc_data = vec[2].adc; tick(); adc_valid = 1'b0;
      repeat (3) tick();
      adc_valid = 1'b1; adc_data = vec[3].adc; tick(); adc_valid = 1'b0;
      tick();
      stop_capture = 1'b1; tick(); stop_capture = 1'b0;
      wait_idle("stop_idle", 20);
      tick();
      chk("stop_count", 32'(sample_count), 32'd2);
      chk("stop_mem0", 32'(mem[0]), 32'(vec[2].exp));
      chk("stop_mem1", 32'(mem[1]), 32'(vec[3].exp));
      readout(2, 2, -1);

      // Reset in the middle of a write with an overrun pending.
      start_capture = 1'b1; tick(); start_capture = 1'b0;
      adc_valid = 1'b1; adc_data = vec[6].adc; tick();
      adc_data = vec[7].adc; tick();
      adc_valid = 1'b0;
      tick();
      chk("pre_rst_overrun", 32'(overrun), 32'd1);
      chk("pre_rst_we_n", 32'(we_n), 32'd0);
      rst = 1'b1; tick();
      w0 = wr_cnt;
      tick(); tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("mrst_writes", 32'(wr_cnt - w0), 32'd0);
      chk("mrst_we_oe", {30'd0, we_n, oe_n}, 32'd3);
      chk("mrst_drive", 32'(dut.u_bus.drive_q), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_count", 32'(sample_count), 32'd0);
      chk("mrst_overrun", 32'(overrun), 32'd0);

      // Capture wins over readout when both start in the same cycle.
      v0 = valid_cnt;
      start_capture = 1'b1; start_readout = 1'b1; tick();
      start_capture = 1'b0; start_readout = 1'b0;
      adc_valid = 1'b1; adc_data = vec[5].adc; tick(); adc_valid = 1'b0;
      repeat (4) tick();
      stop_capture = 1'b1; tick(); stop_capture = 1'b0;
      wait_idle("both_idle", 20);
      tick();
      chk("both_count", 32'(sample_count), 32'd1);
      chk("both_valid", 32'(valid_cnt - v0), 32'd0);
      chk("both_mem", 32'(mem[0]), 32'(vec[5].exp));

      chk("bus_conflict", 32'(conflict_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
